// File: rtl/switch_emu_mc_pkg.sv
// switch_emu_mc_pkg: shared state encodings and trigger-mode constants for the switch emulator.
package switch_emu_mc_pkg;
    typedef enum logic [1:0] {Q_IDLE, Q_PRESS, Q_QUAL, Q_HELD} q_state_t;
    typedef enum logic {T_IDLE, T_ON} t_state_t;
    localparam logic MODE_RELEASE = 1'b0;
    localparam logic MODE_PRESS   = 1'b1;
endpackage

// File: rtl/switch_emu_mc_ch.sv
// switch_emu_mc_ch: one emulator channel, press qualifier plus on-time timer.
module switch_emu_mc_ch
    import switch_emu_mc_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int MIN_PRESS = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pulse,
    input  logic             i_mode_edge,
    input  logic             i_retrig_en,
    input  logic [CNT_W-1:0] i_on_len,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done
);
    localparam int HW = $clog2(MIN_PRESS + 1);
    localparam logic [HW-1:0] MIN_P = HW'(MIN_PRESS);
    localparam logic [HW-1:0] LAST = HW'(MIN_PRESS - 1);
    localparam logic ONE_SHOT = (MIN_PRESS == 1);

    q_state_t         r_q;
    t_state_t         r_t;
    logic [HW-1:0]    r_hcnt;
    logic             r_mode;
    logic             r_pin_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_done;
    logic             w_rise;
    logic             w_mode;
    logic             w_qual;
    logic             w_trig;
    logic             w_load;
    logic [CNT_W-1:0] w_len;

    // the mode of a press is the live input on its first sample, latched afterwards
    always_comb begin
        w_rise = i_pulse & ~r_pin_q;
        w_mode = (r_q == Q_IDLE) ? i_mode_edge : r_mode;
        w_qual = (r_q == Q_IDLE) ? (w_rise & ONE_SHOT) : ((r_q == Q_PRESS) & i_pulse & (r_hcnt == LAST));
        w_trig = (w_qual & (w_mode == MODE_PRESS)) | ((r_q == Q_QUAL) & ~i_pulse);
        w_load = w_trig & ((r_t == T_IDLE) | i_retrig_en);
        w_len  = (i_on_len == '0) ? '0 : i_on_len - CNT_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q     <= Q_IDLE;
            r_hcnt  <= '0;
            r_mode  <= MODE_RELEASE;
            r_pin_q <= 1'b1;
        end else begin
            r_pin_q <= i_pulse;
            case (r_q)
                Q_IDLE: if (w_rise) begin
                    r_mode <= i_mode_edge;
                    r_hcnt <= HW'(1);
                    r_q    <= w_qual ? ((i_mode_edge == MODE_PRESS) ? Q_HELD : Q_QUAL) : Q_PRESS;
                end
                Q_PRESS: begin
                    r_hcnt <= (r_hcnt == MIN_P) ? r_hcnt : r_hcnt + HW'(1);
                    r_q    <= !i_pulse ? Q_IDLE : w_qual ? ((r_mode == MODE_PRESS) ? Q_HELD : Q_QUAL) : Q_PRESS;
                end
                Q_QUAL, Q_HELD: if (!i_pulse) r_q <= Q_IDLE;
                default: r_q <= Q_IDLE;
            endcase
        end
    end

    // a reload on the expiry edge keeps the output high and suppresses done
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_t    <= T_IDLE;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_t   <= T_ON;
                r_cnt <= w_len;
                r_out <= 1'b1;
            end else if (r_t == T_ON) begin
                if (r_cnt == '0) begin
                    r_t    <= T_IDLE;
                    r_out  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign o_pulse = r_out;
    assign o_done  = r_done;
    assign o_busy  = (r_q != Q_IDLE) | (r_t == T_ON);
endmodule

// File: rtl/switch_emu_mc.sv
// switch_emu_mc: NCH independent switch emulator channels sharing mode and width controls.
module switch_emu_mc
    import switch_emu_mc_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CNT_W     = 24,
    parameter int MIN_PRESS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   pulse_in,
    input  logic             mode_edge,
    input  logic             retrig_en,
    input  logic [CNT_W-1:0] on_len,
    output logic [NCH-1:0]   pulse_out,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   done
);
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        switch_emu_mc_ch #(.CNT_W(CNT_W), .MIN_PRESS(MIN_PRESS)) u_ch (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_pulse    (pulse_in[c]),
            .i_mode_edge(mode_edge),
            .i_retrig_en(retrig_en),
            .i_on_len   (on_len),
            .o_pulse    (pulse_out[c]),
            .o_busy     (busy[c]),
            .o_done     (done[c])
        );
    end
endmodule

// File: tb/tb_switch_emu_mc.sv
// tb_switch_emu_mc: directed and random scenarios checked against a press/width reference model.
module tb_switch_emu_mc;
    localparam int NCH = 2;
    localparam int CNT_W = 8;
    localparam int MIN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NCH-1:0]   pulse_in = '0;
    logic             mode_edge = 1'b0;
    logic             retrig_en = 1'b0;
    logic [CNT_W-1:0] on_len = '0;
    logic [NCH-1:0]   pulse_out, busy, done;
    logic [NCH-1:0]   exp_out = '0, exp_busy = '0, exp_done = '0;
    int prev[NCH], plen[NCH], mlat[NCH], rem[NCH];
    int m_old;
    bit m_trig;
    int checks = 0;
    int errors = 0;

    switch_emu_mc #(.NCH(NCH), .CNT_W(CNT_W), .MIN_PRESS(MIN)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .mode_edge(mode_edge),
        .retrig_en(retrig_en), .on_len(on_len),
        .pulse_out(pulse_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // plen counts high samples of a valid press; rem counts remaining high cycles
    always @(posedge clk or posedge rst) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                prev[c] = 1; plen[c] = 0; mlat[c] = 0; rem[c] = 0;
                exp_out[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
            end else begin
                m_trig = 0;
                if (pulse_in[c]) begin
                    if (plen[c] > 0) plen[c]++;
                    else if (prev[c] == 0) begin plen[c] = 1; mlat[c] = int'(mode_edge); end
                    if (plen[c] == MIN && mlat[c] == 1) m_trig = 1;
                end else begin
                    if (plen[c] >= MIN && mlat[c] == 0) m_trig = 1;
                    plen[c] = 0;
                end
                prev[c] = int'(pulse_in[c]);
                m_old = rem[c];
                if (m_trig && (m_old == 0 || retrig_en)) rem[c] = (on_len == 0) ? 1 : int'(on_len);
                else if (m_old > 0) rem[c] = m_old - 1;
                exp_out[c] = rem[c] > 0;
                exp_done[c] = (m_old == 1 && rem[c] == 0);
                exp_busy[c] = (plen[c] > 0 || rem[c] > 0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        checks++;
        if ({pulse_out, busy, done} !== 6'b0) begin
            errors++; $display("FAIL reset out/busy/done=%b/%b/%b exp 0/0/0", pulse_out, busy, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL reset_idle %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_mode_release;
        int hi = 0, dn = 0, oth = 0;
        mode_edge = 1'b0; retrig_en = 1'b0; on_len = 8'd10;
        for (int i = 0; i < 22; i++) begin
            pulse_in[0] = (i >= 1 && i < 6);
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL mode_release %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
            if (i == 6) begin
                checks++;
                if (pulse_out[0] !== 1'b1) begin errors++; $display("FAIL release_latency out=%b exp 1", pulse_out[0]); end
            end
            hi += int'(pulse_out[0]); dn += int'(done[0]); oth += int'(pulse_out[1] | done[1]);
        end
        checks++;
        if (hi != 10 || dn != 1 || oth != 0) begin
            errors++; $display("FAIL release_width hi=%0d done=%0d ch1=%0d exp 10/1/0", hi, dn, oth);
        end
    endtask

    task automatic test_short_press;
        int hi = 0;
        for (int i = 0; i < 10; i++) begin
            pulse_in[0] = (i < 2);
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL short_press %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
            hi += int'(pulse_out[0]);
        end
        checks++;
        if (hi != 0 || busy !== 2'b00) begin errors++; $display("FAIL short_ignored hi=%0d busy=%b exp 0/00", hi, busy); end
        mode_edge = 1'b1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            pulse_in[0] = (i < 17);
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL press_mode %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
            if (i == 2) begin
                checks++;
                if (pulse_out[0] !== 1'b1) begin errors++; $display("FAIL press_latency out=%b exp 1", pulse_out[0]); end
            end
            hi += int'(pulse_out[0]);
        end
        checks++;
        if (hi != 10) begin errors++; $display("FAIL press_no_repeat hi=%0d exp 10", hi); end
    endtask

    task automatic test_retrig;
        for (int r = 0; r < 2; r++) begin
            int hi = 0, dn = 0;
            retrig_en = (r == 0); mode_edge = 1'b1; on_len = 8'd10;
            for (int i = 0; i < 30; i++) begin
                pulse_in[0] = (i < 3) || (i >= 6 && i < 9);
                tick;
                checks++;
                if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                    errors++; $display("FAIL retrig%0d %b/%b/%b exp %b/%b/%b", r, pulse_out, busy, done, exp_out, exp_busy, exp_done);
                end
                hi += int'(pulse_out[0]); dn += int'(done[0]);
            end
            checks++;
            if (hi != (r == 0 ? 16 : 10) || dn != 1) begin
                errors++; $display("FAIL retrig_width en=%0d hi=%0d done=%0d exp %0d/1", retrig_en, hi, dn, r == 0 ? 16 : 10);
            end
        end
    endtask

    task automatic test_on_len;
        int lens[3] = '{0, 255, 10};
        int want[3] = '{1, 255, 10};
        mode_edge = 1'b1; retrig_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int hi = 0;
            on_len = 8'(lens[k]);
            for (int i = 0; i < 262; i++) begin
                pulse_in[0] = (i < 3);
                if (k == 2 && i == 5) on_len = 8'd3;
                tick;
                checks++;
                if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                    errors++; $display("FAIL on_len%0d %b/%b/%b exp %b/%b/%b", k, pulse_out, busy, done, exp_out, exp_busy, exp_done);
                end
                hi += int'(pulse_out[0]);
            end
            checks++;
            if (hi != want[k]) begin errors++; $display("FAIL on_len_width case=%0d hi=%0d exp %0d", k, hi, want[k]); end
        end
    endtask

    task automatic test_async_reset;
        int hi = 0;
        mode_edge = 1'b1; on_len = 8'd20;
        pulse_in = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL pre_reset %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pulse_out, busy, done} !== 6'b0) begin
            errors++; $display("FAIL async_reset out/busy/done=%b/%b/%b exp 0/0/0", pulse_out, busy, done);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL held_across_reset %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
            hi += int'(pulse_out[0]) + int'(pulse_out[1]);
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL held_no_trigger hi=%0d exp 0", hi); end
        pulse_in = 2'b00;
        tick;
        pulse_in = 2'b11;
        tick; tick; tick;
        checks++;
        if (pulse_out !== 2'b11) begin errors++; $display("FAIL repress_after_reset out=%b exp 11", pulse_out); end
        pulse_in = 2'b00;
        for (int i = 0; i < 25; i++) begin
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL post_reset %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_both_channels;
        int hi0 = 0, hi1 = 0, dn0 = 0, dn1 = 0, same = 1;
        mode_edge = 1'b1; retrig_en = 1'b0; on_len = 8'd6;
        for (int i = 0; i < 14; i++) begin
            pulse_in = (i < 3) ? 2'b11 : 2'b00;
            tick;
            if (pulse_out[0] !== pulse_out[1] || done[0] !== done[1]) same = 0;
            hi0 += int'(pulse_out[0]);
        end
        checks++;
        if (same != 1 || hi0 != 6) begin errors++; $display("FAIL same_edge same=%0d hi=%0d exp 1/6", same, hi0); end
        hi0 = 0;
        for (int i = 0; i < 20; i++) begin
            pulse_in[0] = (i < 3);
            pulse_in[1] = (i >= 1 && i < 4);
            on_len = (i < 3) ? 8'd4 : 8'd9;
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL both_ch %b/%b/%b exp %b/%b/%b", pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
            hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]); dn0 += int'(done[0]); dn1 += int'(done[1]);
        end
        checks++;
        if (hi0 != 4 || hi1 != 9 || dn0 != 1 || dn1 != 1) begin
            errors++; $display("FAIL independent hi=%0d/%0d done=%0d/%0d exp 4/9 1/1", hi0, hi1, dn0, dn1);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NCH; c++) if ($urandom_range(3) == 0) pulse_in[c] = ~pulse_in[c];
            if ($urandom_range(49) == 0) mode_edge = 1'($urandom_range(1));
            if ($urandom_range(29) == 0) retrig_en = 1'($urandom_range(1));
            on_len = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
            tick;
            checks++;
            if ({pulse_out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                errors++; $display("FAIL random i=%0d %b/%b/%b exp %b/%b/%b", i, pulse_out, busy, done, exp_out, exp_busy, exp_done);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mode_release;
        test_short_press;
        test_retrig;
        test_on_len;
        test_async_reset;
        test_both_channels;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
